// File: rtl/formula_stream_if.sv
// Streaming handshake bundle for formula_stream.
// master = producer/consumer side, slave = the datapath.
interface formula_stream_if #(
    parameter int N     = 8,
    parameter int TAG_W = 4
);
    logic                i_valid;
    logic                i_ready;
    logic signed [N-1:0] a;
    logic signed [N-1:0] b;
    logic signed [N-1:0] c;
    logic signed [N-1:0] d;
    logic                i_wrap;
    logic [TAG_W-1:0]    i_tag;
    logic                o_valid;
    logic                o_ready;
    logic signed [N-1:0] q;
    logic [TAG_W-1:0]    o_tag;
    logic                o_sat;

    modport master (
        output i_valid, a, b, c, d, i_wrap, i_tag, o_ready,
        input  i_ready, o_valid, q, o_tag, o_sat
    );

    modport slave (
        input  i_valid, a, b, c, d, i_wrap, i_tag, o_ready,
        output i_ready, o_valid, q, o_tag, o_sat
    );
endinterface

// File: rtl/formula_stream.sv
// formula_stream: 5-stage streaming datapath computing
//   q = clamp_or_wrap((((a-b)*(1+3c)) - 4d) >>> 1)
// Ports: clk, rst (sync, active-high); bus (formula_stream_if.slave:
//   i_valid/i_ready, a, b, c, d, i_wrap, i_tag in;
//   o_valid/o_ready, q, o_tag, o_sat out);
//   sat_clr in, sat_cnt out (saturating clamp-event counter).
// Option: define FORMULA_STREAM_ROUND_EN to round half toward +inf in S4.
module formula_stream #(
    parameter int N     = 8,
    parameter int TAG_W = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    formula_stream_if.slave  bus,
    input  logic             sat_clr,
    output logic [CNT_W-1:0] sat_cnt
);
    // Wide enough that no intermediate can overflow.
    localparam int W = 2 * N + 4;
    localparam logic signed [W-1:0] ONE  = W'(1);
    localparam logic signed [W-1:0] MAXV = W'((2 ** (N - 1)) - 1);
    localparam logic signed [W-1:0] MINV = -W'(2 ** (N - 1));

    logic                w_adv;
    logic signed [W-1:0] w_a;
    logic signed [W-1:0] w_b;
    logic signed [W-1:0] w_c;
    logic signed [W-1:0] w_d;
    logic signed [W-1:0] w_y;
    logic                w_hi;
    logic                w_lo;
    logic [N-1:0]        w_q;
    logic                w_sat;

    // S1
    logic                r_v1;
    logic signed [W-1:0] r_diff1;
    logic signed [W-1:0] r_mul1;
    logic signed [W-1:0] r_d4_1;
    logic                r_wrap1;
    logic [TAG_W-1:0]    r_tag1;
    // S2
    logic                r_v2;
    logic signed [W-1:0] r_prod2;
    logic signed [W-1:0] r_d4_2;
    logic                r_wrap2;
    logic [TAG_W-1:0]    r_tag2;
    // S3
    logic                r_v3;
    logic signed [W-1:0] r_x3;
    logic                r_wrap3;
    logic [TAG_W-1:0]    r_tag3;
    // S4
    logic                r_v4;
    logic signed [W-1:0] r_y4;
    logic                r_wrap4;
    logic [TAG_W-1:0]    r_tag4;
    // S5 (outputs)
    logic                r_v5;
    logic [N-1:0]        r_q;
    logic [TAG_W-1:0]    r_tag5;
    logic                r_sat5;
    logic [CNT_W-1:0]    r_cnt;

    // Whole pipeline moves as one; a held output stalls every stage.
    assign w_adv       = !r_v5 || bus.o_ready;
    assign bus.i_ready = w_adv;

    assign w_a = {{(W - N){bus.a[N-1]}}, bus.a};
    assign w_b = {{(W - N){bus.b[N-1]}}, bus.b};
    assign w_c = {{(W - N){bus.c[N-1]}}, bus.c};
    assign w_d = {{(W - N){bus.d[N-1]}}, bus.d};

`ifdef FORMULA_STREAM_ROUND_EN
    assign w_y = (r_x3 + ONE) >>> 1;
`else
    assign w_y = r_x3 >>> 1;
`endif

    assign w_hi = r_y4 > MAXV;
    assign w_lo = r_y4 < MINV;

    always_comb begin
        w_q   = r_y4[N-1:0];
        w_sat = 1'b0;
        if (!r_wrap4) begin
            if (w_hi) begin
                w_q   = MAXV[N-1:0];
                w_sat = 1'b1;
            end else if (w_lo) begin
                w_q   = MINV[N-1:0];
                w_sat = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_v1    <= 1'b0;
            r_diff1 <= '0;
            r_mul1  <= '0;
            r_d4_1  <= '0;
            r_wrap1 <= 1'b0;
            r_tag1  <= '0;
            r_v2    <= 1'b0;
            r_prod2 <= '0;
            r_d4_2  <= '0;
            r_wrap2 <= 1'b0;
            r_tag2  <= '0;
            r_v3    <= 1'b0;
            r_x3    <= '0;
            r_wrap3 <= 1'b0;
            r_tag3  <= '0;
            r_v4    <= 1'b0;
            r_y4    <= '0;
            r_wrap4 <= 1'b0;
            r_tag4  <= '0;
            r_v5    <= 1'b0;
            r_q     <= '0;
            r_tag5  <= '0;
            r_sat5  <= 1'b0;
        end else if (w_adv) begin
            r_v1    <= bus.i_valid;
            r_diff1 <= w_a - w_b;
            r_mul1  <= w_c + w_c + w_c + ONE;
            r_d4_1  <= w_d <<< 2;
            r_wrap1 <= bus.i_wrap;
            r_tag1  <= bus.i_tag;

            r_v2    <= r_v1;
            r_prod2 <= r_diff1 * r_mul1;
            r_d4_2  <= r_d4_1;
            r_wrap2 <= r_wrap1;
            r_tag2  <= r_tag1;

            r_v3    <= r_v2;
            r_x3    <= r_prod2 - r_d4_2;
            r_wrap3 <= r_wrap2;
            r_tag3  <= r_tag2;

            r_v4    <= r_v3;
            r_y4    <= w_y;
            r_wrap4 <= r_wrap3;
            r_tag4  <= r_tag3;

            r_v5    <= r_v4;
            r_q     <= w_q;
            r_tag5  <= r_tag4;
            r_sat5  <= w_sat;
        end
    end

    // Counts clamped beats actually handed to the consumer.
    always_ff @(posedge clk) begin
        if (rst || sat_clr) begin
            r_cnt <= '0;
        end else if (r_v5 && bus.o_ready && r_sat5 && (r_cnt != '1)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign bus.o_valid = r_v5;
    assign bus.q       = r_q;
    assign bus.o_tag   = r_tag5;
    assign bus.o_sat   = r_sat5;
    assign sat_cnt     = r_cnt;
endmodule

// File: tb/tb_formula_stream.sv
// Self-checking bench for formula_stream: directed vector table,
// backpressure/counter/reset sequences and a randomized scoreboard run.
module tb_formula_stream;
    localparam int N     = 8;
    localparam int TAG_W = 4;
    localparam int M     = 2 ** N;

    logic clk;
    logic rst;
    logic sat_clr;
    logic [15:0] sat_cnt;
    logic [1:0]  sat_cnt2;

    formula_stream_if #(.N(N), .TAG_W(TAG_W)) if1 ();
    formula_stream_if #(.N(N), .TAG_W(TAG_W)) if2 ();

    assign if2.i_valid = if1.i_valid;
    assign if2.a       = if1.a;
    assign if2.b       = if1.b;
    assign if2.c       = if1.c;
    assign if2.d       = if1.d;
    assign if2.i_wrap  = if1.i_wrap;
    assign if2.i_tag   = if1.i_tag;
    assign if2.o_ready = if1.o_ready;

    formula_stream #(.N(N), .TAG_W(TAG_W), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .bus(if1.slave),
        .sat_clr(sat_clr), .sat_cnt(sat_cnt)
    );

    formula_stream #(.N(N), .TAG_W(TAG_W), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .bus(if2.slave),
        .sat_clr(sat_clr), .sat_cnt(sat_cnt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: plain integer arithmetic with explicit floor division.
    task automatic model(input int a, input int b, input int c, input int d,
                         input bit wrap, output int q, output bit sat);
        int x;
        int y;
        int hi;
        int lo;
        int m;
        x = (a - b) * (1 + 3 * c) - 4 * d;
`ifdef FORMULA_STREAM_ROUND_EN
        x = x + 1;
`endif
        if (x >= 0) y = x / 2;
        else        y = -((-x + 1) / 2);
        hi  = M / 2 - 1;
        lo  = -(M / 2);
        sat = 1'b0;
        if (wrap) begin
            m = ((y % M) + M) % M;
            q = (m > hi) ? m - M : m;
        end else if (y > hi) begin
            q   = hi;
            sat = 1'b1;
        end else if (y < lo) begin
            q   = lo;
            sat = 1'b1;
        end else begin
            q = y;
        end
    endtask

    typedef struct {
        int q;
        bit sat;
        int tag;
    } exp_t;

    exp_t sb[$];
    int   mcnt  = 0;
    int   mcnt2 = 0;
    int   n_out = 0;
    bit   hold  = 1'b0;
    int   hq;
    int   htag;
    int   hsat;

    // Scoreboard monitor, sampled on the falling edge.
    always @(negedge clk) begin
        exp_t e;
        int   ia, ib, ic, id;
        bit   xsat;
        bit   xfer;
        if (rst) begin
            sb.delete();
            mcnt  = 0;
            mcnt2 = 0;
            hold  = 1'b0;
        end else begin
            chk("sat_cnt", int'(sat_cnt), mcnt);
            chk("sat_cnt_w2", int'(sat_cnt2), mcnt2);
            if (hold) begin
                chk("hold_q", int'(if1.q), hq);
                chk("hold_tag", int'(if1.o_tag), htag);
                chk("hold_sat", int'(if1.o_sat), hsat);
            end
            xsat = 1'b0;
            xfer = if1.o_valid && if1.o_ready;
            if (xfer) begin
                n_out++;
                chk("out_expected", int'(sb.size() != 0), 1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    chk("q", int'(if1.q), e.q);
                    chk("o_tag", int'(if1.o_tag), e.tag);
                    chk("o_sat", int'(if1.o_sat), int'(e.sat));
                    xsat = e.sat;
                end
            end
            if (if1.i_valid && if1.i_ready) begin
                ia = if1.a;
                ib = if1.b;
                ic = if1.c;
                id = if1.d;
                model(ia, ib, ic, id, if1.i_wrap, e.q, e.sat);
                e.tag = int'(if1.i_tag);
                sb.push_back(e);
            end
            if (sat_clr) begin
                mcnt  = 0;
                mcnt2 = 0;
            end else if (xfer && xsat) begin
                if (mcnt < 65535) mcnt++;
                if (mcnt2 < 3) mcnt2++;
            end
            hold = if1.o_valid && !if1.o_ready;
            hq   = int'(if1.q);
            htag = int'(if1.o_tag);
            hsat = int'(if1.o_sat);
        end
    end

    typedef struct {
        int a;
        int b;
        int c;
        int d;
        bit w;
        int q;
        bit sat;
    } vec_t;

    vec_t vt[10];

    task automatic drive(input int a, input int b, input int c, input int d,
                         input bit w, input int tag);
        if1.a      = N'(a);
        if1.b      = N'(b);
        if1.c      = N'(c);
        if1.d      = N'(d);
        if1.i_wrap = w;
        if1.i_tag  = TAG_W'(tag);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        if1.i_valid = 1'b0;
        if1.o_ready = 1'b1;
        for (int k = 0; k < 100 && (sb.size() != 0 || if1.o_valid); k++)
            tick();
        chk("drain", sb.size(), 0);
    endtask

    task automatic send_clamped(input int n);
        for (int k = 0; k < n; k++) begin
            if1.i_valid = 1'b1;
            drive(120, -25, 7, 6, 1'b0, k);
            tick();
        end
        drain();
    endtask

    initial begin
        int cnt0;
        int sent;
        bit acc;
        rst         = 1'b1;
        sat_clr     = 1'b0;
        if1.i_valid = 1'b0;
        if1.o_ready = 1'b1;
        drive(0, 0, 0, 0, 1'b0, 0);
        tick();
        tick();
        chk("rst_o_valid", int'(if1.o_valid), 0);
        chk("rst_q", int'(if1.q), 0);
        chk("rst_o_tag", int'(if1.o_tag), 0);
        chk("rst_o_sat", int'(if1.o_sat), 0);
        chk("rst_sat_cnt", int'(sat_cnt), 0);
        rst = 1'b0;
        tick();

        vt[0] = '{1, 2, 3, 4, 1'b0, -13, 1'b0};
        vt[1] = '{10, 20, 5, 10, 1'b0, -100, 1'b0};
        vt[2] = '{120, -25, 7, 6, 1'b0, 127, 1'b1};
        vt[3] = '{120, -25, 7, 6, 1'b1, 47, 1'b0};
        vt[4] = '{-5, 10, -20, -1, 1'b0, 127, 1'b1};
        vt[5] = '{127, -127, 0, 0, 1'b0, 127, 1'b0};
        vt[6] = '{-128, 0, 0, 32, 1'b0, -128, 1'b0};
        vt[7] = '{-128, 0, 0, 33, 1'b0, -128, 1'b1};
`ifdef FORMULA_STREAM_ROUND_EN
        vt[8] = '{2, 1, 0, 0, 1'b0, 1, 1'b0};
        vt[9] = '{1, 2, 0, 0, 1'b0, 0, 1'b0};
`else
        vt[8] = '{2, 1, 0, 0, 1'b0, 0, 1'b0};
        vt[9] = '{1, 2, 0, 0, 1'b0, -1, 1'b0};
`endif

        for (int i = 0; i < 10; i++) begin
            if1.i_valid = 1'b1;
            drive(vt[i].a, vt[i].b, vt[i].c, vt[i].d, vt[i].w, i);
            chk("vec_i_ready", int'(if1.i_ready), 1);
            for (int k = 1; k <= 5; k++) begin
                tick();
                if1.i_valid = 1'b0;
                if (k < 5) chk("vec_early", int'(if1.o_valid), 0);
            end
            chk("vec_o_valid", int'(if1.o_valid), 1);
            chk("vec_q", int'(if1.q), vt[i].q);
            chk("vec_o_sat", int'(if1.o_sat), int'(vt[i].sat));
            drain();
        end

        // Back-to-back stream with a four-cycle consumer stall.
        cnt0 = n_out;
        sent = 0;
        drive($urandom, $urandom, $urandom, $urandom, $urandom % 2, 0);
        for (int cyc = 0; cyc < 40; cyc++) begin
            if1.o_ready = !(cyc >= 6 && cyc <= 9);
            if1.i_valid = (sent < 8);
            #1;
            if (cyc >= 6 && cyc <= 9) chk("bp_i_ready", int'(if1.i_ready), 0);
            acc = if1.i_valid && if1.i_ready;
            @(posedge clk);
            #1;
            if (acc) begin
                sent++;
                drive($urandom, $urandom, $urandom, $urandom,
                      $urandom % 2, sent);
            end
        end
        drain();
        chk("bp_count", n_out - cnt0, 8);

        // Randomized traffic with random stalls and clears.
        for (int cyc = 0; cyc < 600; cyc++) begin
            if1.i_valid = ($urandom % 4) != 0;
            if1.o_ready = ($urandom % 3) != 0;
            sat_clr     = ($urandom % 60) == 0;
            drive($urandom, $urandom, $urandom, $urandom,
                  $urandom % 2, $urandom);
            tick();
        end
        sat_clr = 1'b0;
        drain();

        // Counter: three clamps, clear against a fourth, then saturate.
        sat_clr = 1'b1;
        tick();
        sat_clr = 1'b0;
        send_clamped(3);
        chk("cnt_three", int'(sat_cnt), 3);
        if1.i_valid = 1'b1;
        drive(120, -25, 7, 6, 1'b0, 9);
        for (int k = 1; k <= 5; k++) begin
            tick();
            if1.i_valid = 1'b0;
        end
        chk("clr_beat_sat", int'(if1.o_valid && if1.o_sat), 1);
        chk("clr_before", int'(sat_cnt), 3);
        sat_clr = 1'b1;
        tick();
        sat_clr = 1'b0;
        chk("clr_wins", int'(sat_cnt), 0);
        drain();
        send_clamped(5);
        chk("cnt_five", int'(sat_cnt), 5);
        chk("cnt_w2_hold", int'(sat_cnt2), 3);

        // Reset with three beats in flight.
        for (int k = 0; k < 3; k++) begin
            if1.i_valid = 1'b1;
            drive(120, -25, 7, 6, 1'b0, k);
            tick();
        end
        if1.i_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_o_valid", int'(if1.o_valid), 0);
        chk("mid_rst_q", int'(if1.q), 0);
        chk("mid_rst_sat_cnt", int'(sat_cnt), 0);
        cnt0 = 0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (if1.o_valid) cnt0++;
        end
        chk("mid_rst_no_out", cnt0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/formula_stream.md
Name: formula_stream

Overview:
- Parametrised successor of the fixed-function `formula` datapath.
- Computes q = clamp_or_wrap((((a - b) * (1 + 3*c)) - 4*d) >>> 1) on N-bit signed operands.
- Adds valid/ready backpressure, a per-transaction saturate/wrap mode, a sideband tag carried alongside the data, and a sticky saturating clamp-event counter.
- Sits between a streaming producer and a consumer that may stall.

Parameters:
N, 8, operand and result width in bits (signed, N >= 4)
TAG_W, 4, width of the sideband tag carried alongside the data (>= 1)
CNT_W, 16, width of the clamp-event counter

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
i_valid  in  1  input beat valid
i_ready  out  1  block can accept an input beat this cycle
a  in  N  signed operand
b  in  N  signed operand
c  in  N  signed operand
d  in  N  signed operand
i_wrap  in  1  1 = wrap result to N bits; 0 = saturate
i_tag  in  TAG_W  sideband tag, returned unchanged with the result
o_valid  out  1  output beat valid
o_ready  in  1  consumer accepts the output beat
q  out  N  signed result
o_tag  out  TAG_W  tag of the current output beat
o_sat  out  1  the current output beat was clamped
sat_cnt  out  CNT_W  number of clamped beats accepted since reset or clear
sat_clr  in  1  synchronous clear of sat_cnt

Behaviour:
- Interface: one clock `clk`; synchronous active-high reset `rst`, sampled on the rising edge of `clk`.
- Reset values: o_valid=0, q=0, o_tag=0, o_sat=0, sat_cnt=0, and all internal stage valids=0.
- Reset mid-operation: in-flight beats are discarded without producing output.
- Internal width: W = 2N+4 bits signed; all intermediates are sign-extended to W bits, so no internal overflow is possible.
- Pipeline: 5 registered stages; latency is exactly 5 cycles from an accepted input to o_valid when unstalled.
  - S1: register a-b, 1+3c, 4d, i_wrap, i_tag.
  - S2: product (a-b)*(1+3c).
  - S3: subtract 4d.
  - S4: arithmetic shift right by 1 (floor).
  - S5: clamp or wrap to N bits; register into q, o_tag, o_sat.
- Clamp (i_wrap=0):
  - result > 2^(N-1)-1 gives 2^(N-1)-1 with o_sat=1.
  - result < -2^(N-1) gives -2^(N-1) with o_sat=1.
  - otherwise the low N bits with o_sat=0.
- Wrap (i_wrap=1): q is the low N bits of the result; o_sat=0 always.
- Handshake:
  - Global stall: adv = !o_valid || o_ready.
  - i_ready = adv (combinational from o_ready and o_valid).
  - An input beat is accepted when i_valid && i_ready.
  - An output beat is transferred when o_valid && o_ready.
  - When adv=0, every stage register, including q, o_tag and o_sat, holds its value.
  - Bubbles are not collapsed.
  - Full throughput: 1 beat per cycle while o_ready=1.
  - No beat is lost or duplicated under any o_ready pattern; output order equals input order.
- i_valid=0 while adv=1: a bubble enters S1; operand registers may hold stale data.
- sat_cnt:
  - Increments by 1 on each transferred beat with o_sat=1.
  - Holds at 2^CNT_W-1 and does not wrap.
  - sat_clr=1 sets it to 0 on the next edge; clear wins over a simultaneous increment.

Optional Feature:
- Macro: FORMULA_STREAM_ROUND_EN.
- Defined: S4 computes (x + 1) >>> 1, i.e. rounds half toward +infinity.
  - Latency is unchanged.
  - Clamp and wrap are applied to the rounded value.
- Undefined: S4 is the plain floor shift x >>> 1, with no extra adder.

Test Plan:
- N=8, i_wrap=0, o_ready=1: a=1,b=2,c=3,d=4 -> q=-13; a=10,b=20,c=5,d=10 -> q=-100. Each has o_sat=0 and appears exactly 5 cycles after acceptance.
- N=8 overflow:
  - a=120,b=-25,c=7,d=6, i_wrap=0 -> q=127, o_sat=1, sat_cnt increments by 1.
  - Same operands with i_wrap=1 -> q=47, o_sat=0.
  - a=-5,b=10,c=-20,d=-1, i_wrap=0 -> q=127.
- Back-to-back and backpressure:
  - Stream 8 beats with tags 0..7 while o_ready is held at 0 for cycles 6-9.
  - Required: i_ready=0 in those cycles, and q/o_tag stable while o_valid && !o_ready.
  - Required: all 8 results delivered in tag order with correct values.
- Rounding:
  - a=2,b=1,c=0,d=0 -> q=0 without FORMULA_STREAM_ROUND_EN, q=1 with it.
  - a=1,b=2,c=0,d=0 -> q=-1 without, q=0 with.
- Counter:
  - Force 3 clamped beats -> sat_cnt=3.
  - Assert sat_clr in the same cycle as a 4th clamped transfer -> sat_cnt=0.
  - Preload with CNT_W=2 and 5 clamped beats -> sat_cnt holds at 3.
- Reset mid-stream:
  - Assert rst for 1 cycle while 3 beats are in flight.
  - Required next cycle: o_valid=0, q=0, sat_cnt=0.
  - Required: no output ever appears for the discarded beats.
